// File: rtl/fifo_sync_flex_if.sv
// Purpose: bundles the producer/consumer-facing signals of fifo_sync_flex.
// Latency: none, wiring only.
// Backpressure: none here; full/overflow and empty/underflow report refusals.
// Ports (slave = FIFO side):
//   wr_n, rd_n, din       requests and write data from the user
//   dout, dout_vld        registered read data and its 1-cycle strobe
//   count, empty, full    occupancy and its exact-level decodes
//   almost_empty/full     threshold decodes of count
//   overflow, underflow   1-cycle strobes for rejected requests
interface fifo_sync_flex_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 5
);
  logic                  wr_n;
  logic                  rd_n;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_vld;
  logic [CNT_W-1:0]      count;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_n, rd_n, din,
    input  dout, dout_vld, count, empty, full,
           almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  wr_n, rd_n, din,
    output dout, dout_vld, count, empty, full,
           almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flex.sv
// Purpose: single-clock FIFO with occupancy counter (any depth >= 2, all entries usable).
// Latency: accepted read data appears on dout one cycle after the read edge.
// Backpressure: writes refused when full unless a read is accepted in the same cycle;
//               reads refused when empty (no write-to-read bypass); refusals strobe overflow/underflow.
// Ports:
//   clk    clock, all logic on posedge
//   rst_n  synchronous active-low reset (memory contents are not cleared)
//   bus    fifo_sync_flex_if.slave: requests, data, count, flags and error strobes
module fifo_sync_flex #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_sync_flex_if.slave  bus
);

  localparam int PTR_W = ($clog2(FIFO_DEPTH) > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_vld_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic empty_w;
  logic full_w;
  logic rd_acc;
  logic wr_acc;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CNT_FULL);

  // A full FIFO can still take a write when a read frees a slot in the same
  // cycle; the read fetches the old word at rd_ptr == wr_ptr before it is overwritten.
  assign rd_acc = !bus.rd_n && !empty_w;
  assign wr_acc = !bus.wr_n && (!full_w || rd_acc);

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage has no reset; stale contents are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[wr_ptr] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= ptr_next(rd_ptr);
        dout_q <= mem[rd_ptr];
      end
      dout_vld_q <= rd_acc;

      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      overflow_q  <= !bus.wr_n && !wr_acc;
      underflow_q <= !bus.rd_n && !rd_acc;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.dout_vld     = dout_vld_q;
  assign bus.count        = count_q;
  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_empty = (count_q <= CNT_AE);
  assign bus.almost_full  = (count_q >= CNT_AF);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Purpose: self-checking bench for fifo_sync_flex (depth 16 and depth 5 instances).
// Latency: expects read data one cycle after an accepted read.
// Backpressure: exercises overflow/underflow refusals and full read+write.
module tb_fifo_sync_flex;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_sync_flex_if #(.DATA_WIDTH(8), .CNT_W(5)) b16 ();
  fifo_sync_flex_if #(.DATA_WIDTH(8), .CNT_W(3)) b5 ();

  fifo_sync_flex #(.FIFO_DEPTH(16), .DATA_WIDTH(8), .AF_LEVEL(14), .AE_LEVEL(2)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16)
  );

  fifo_sync_flex #(.FIFO_DEPTH(5), .DATA_WIDTH(8), .AF_LEVEL(4), .AE_LEVEL(1)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b5)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: plain queues ----------------
  logic [7:0] q16[$];
  logic [7:0] q5[$];
  logic [7:0] e16_dout, e5_dout;
  bit e16_vld, e16_ov, e16_un, e5_vld, e5_ov, e5_un;
  bit ra16, wa16, ra5, wa5;
  bit started = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q16.delete(); q5.delete();
      e16_dout = 8'h00; e16_vld = 0; e16_ov = 0; e16_un = 0;
      e5_dout  = 8'h00; e5_vld  = 0; e5_ov  = 0; e5_un  = 0;
      started  = 1'b1;
    end else begin
      ra16 = !b16.rd_n && (q16.size() > 0);
      wa16 = !b16.wr_n && (q16.size() < 16 || ra16);
      e16_ov = !b16.wr_n && !wa16;
      e16_un = !b16.rd_n && !ra16;
      e16_vld = ra16;
      if (ra16) e16_dout = q16.pop_front();
      if (wa16) q16.push_back(b16.din);

      ra5 = !b5.rd_n && (q5.size() > 0);
      wa5 = !b5.wr_n && (q5.size() < 5 || ra5);
      e5_ov = !b5.wr_n && !wa5;
      e5_un = !b5.rd_n && !ra5;
      e5_vld = ra5;
      if (ra5) e5_dout = q5.pop_front();
      if (wa5) q5.push_back(b5.din);
    end
    #1;
    if (started) begin
      chk("m16_dout",  32'(b16.dout),         32'(e16_dout));
      chk("m16_vld",   32'(b16.dout_vld),     32'(e16_vld));
      chk("m16_count", 32'(b16.count),        q16.size());
      chk("m16_empty", 32'(b16.empty),        32'(q16.size() == 0));
      chk("m16_full",  32'(b16.full),         32'(q16.size() == 16));
      chk("m16_ae",    32'(b16.almost_empty), 32'(q16.size() <= 2));
      chk("m16_af",    32'(b16.almost_full),  32'(q16.size() >= 14));
      chk("m16_ov",    32'(b16.overflow),     32'(e16_ov));
      chk("m16_un",    32'(b16.underflow),    32'(e16_un));
      chk("m5_dout",   32'(b5.dout),          32'(e5_dout));
      chk("m5_vld",    32'(b5.dout_vld),      32'(e5_vld));
      chk("m5_count",  32'(b5.count),         q5.size());
      chk("m5_empty",  32'(b5.empty),         32'(q5.size() == 0));
      chk("m5_full",   32'(b5.full),          32'(q5.size() == 5));
      chk("m5_ae",     32'(b5.almost_empty),  32'(q5.size() <= 1));
      chk("m5_af",     32'(b5.almost_full),   32'(q5.size() >= 4));
      chk("m5_ov",     32'(b5.overflow),      32'(e5_ov));
      chk("m5_un",     32'(b5.underflow),     32'(e5_un));
    end
  end

  // ---------------- stimulus helpers (called at negedge) ----------------
  task automatic cyc16(input bit w, input bit r, input logic [7:0] d);
    b16.wr_n = !w; b16.rd_n = !r; b16.din = d;
    @(negedge clk);
    b16.wr_n = 1'b1; b16.rd_n = 1'b1;
  endtask

  task automatic cyc5(input bit w, input bit r, input logic [7:0] d);
    b5.wr_n = !w; b5.rd_n = !r; b5.din = d;
    @(negedge clk);
    b5.wr_n = 1'b1; b5.rd_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pushed;
    int cycles;
    b16.wr_n = 1'b1; b16.rd_n = 1'b1; b16.din = 8'h00;
    b5.wr_n  = 1'b1; b5.rd_n  = 1'b1; b5.din  = 8'h00;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_count", 32'(b16.count), 0);
    chk("rst_empty", 32'(b16.empty), 1);
    chk("rst_dout",  32'(b16.dout), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: fill 16, then overflow
    for (int k = 1; k <= 16; k++) begin
      cyc16(1, 0, 8'(k));
      chk("t1_count", 32'(b16.count), k);
      chk("t1_af", 32'(b16.almost_full), (k >= 14) ? 1 : 0);
    end
    chk("t1_full", 32'(b16.full), 1);
    cyc16(1, 0, 8'h99);
    chk("t1_ovf", 32'(b16.overflow), 1);
    chk("t1_cnt_hold", 32'(b16.count), 16);
    @(negedge clk);
    chk("t1_ovf_clr", 32'(b16.overflow), 0);

    // 2: drain 16, then underflow
    for (int i = 1; i <= 16; i++) begin
      cyc16(0, 1, 8'h00);
      chk("t2_dout", 32'(b16.dout), i);
      chk("t2_vld", 32'(b16.dout_vld), 1);
    end
    chk("t2_empty", 32'(b16.empty), 1);
    cyc16(0, 1, 8'h00);
    chk("t2_unf", 32'(b16.underflow), 1);
    chk("t2_dout_hold", 32'(b16.dout), 32'h10);
    chk("t2_vld_low", 32'(b16.dout_vld), 0);

    // 3: full FIFO, simultaneous read+write
    for (int i = 0; i < 16; i++) cyc16(1, 0, 8'(8'h21 + i));
    cyc16(1, 1, 8'hAA);
    chk("t3_ovf", 32'(b16.overflow), 0);
    chk("t3_count", 32'(b16.count), 16);
    chk("t3_dout", 32'(b16.dout), 32'h21);
    for (int i = 0; i < 15; i++) begin
      cyc16(0, 1, 8'h00);
      chk("t3_drain", 32'(b16.dout), 32'h22 + i);
    end
    cyc16(0, 1, 8'h00);
    chk("t3_aa", 32'(b16.dout), 32'hAA);
    chk("t3_empty", 32'(b16.empty), 1);

    // 4: empty FIFO, simultaneous read+write
    cyc16(1, 1, 8'h55);
    chk("t4_unf", 32'(b16.underflow), 1);
    chk("t4_count", 32'(b16.count), 1);
    chk("t4_vld", 32'(b16.dout_vld), 0);
    cyc16(0, 1, 8'h00);
    chk("t4_dout", 32'(b16.dout), 32'h55);

    // 5: depth-5 wrap with mixed operations
    pushed = 0;
    cycles = 0;
    while (pushed < 40 && cycles < 1000) begin
      bit w, r;
      w = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 1) != 0);
      if (w && (q5.size() < 5 || (r && q5.size() > 0))) pushed++;
      cyc5(w, r, 8'($urandom_range(0, 255)));
      chk("t5_bound", 32'(b5.count <= 3'd5), 1);
      cycles++;
    end
    chk("t5_pushed", pushed, 40);
    for (int i = 0; i < 6; i++) cyc5(0, 1, 8'h00);
    chk("t5_drained", 32'(b5.count), 0);

    // 6: reset with 9 entries
    for (int i = 0; i < 9; i++) cyc16(1, 0, 8'(8'h40 + i));
    chk("t6_pre", 32'(b16.count), 9);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_count", 32'(b16.count), 0);
    chk("t6_empty", 32'(b16.empty), 1);
    chk("t6_dout", 32'(b16.dout), 0);
    chk("t6_flags", 32'({b16.full, b16.almost_empty, b16.almost_full,
                         b16.overflow, b16.underflow, b16.dout_vld}), 32'b010000);
    cyc16(1, 0, 8'h77);
    chk("t6_wr", 32'(b16.count), 1);
    cyc16(0, 1, 8'h00);
    chk("t6_rd", 32'(b16.dout), 32'h77);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
